// File: rtl/uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_bridge
// Purpose  : Turns UART command frames (57 addr data / 52 addr) into 8-bit
//            register accesses and answers each one with a single byte.
// Revision : 1.0
// ============================================================================
module uart_cmd_bridge #(
    parameter int unsigned P_TIMEOUT_CYCLES = 100_000,
    parameter logic [7:0]  P_ACK_BYTE       = 8'h06,
    parameter logic [7:0]  P_NAK_BYTE       = 8'h15
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_rx_parity_err,
    input  logic       i_rx_framing_err,
    output logic       o_rx_read_en,
    output logic [7:0] o_tx_data,
    output logic       o_tx_write_en,
    input  logic       i_tx_full,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_wr,
    output logic       o_reg_rd,
    input  logic [7:0] i_reg_rdata,
    input  logic       i_reg_ready,
    output logic       o_busy
);

    localparam int unsigned        c_cnt_w    = (P_TIMEOUT_CYCLES > 1) ? $clog2(P_TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(P_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [7:0]         c_op_write = 8'h57;
    localparam logic [7:0]         c_op_read  = 8'h52;

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_get_addr = 3'd1;
    localparam logic [2:0] c_get_data = 3'd2;
    localparam logic [2:0] c_bus_wr   = 3'd3;
    localparam logic [2:0] c_bus_rd   = 3'd4;
    localparam logic [2:0] c_send     = 3'd5;

    logic [2:0]         r_state,   w_state_nxt;
    logic [c_cnt_w-1:0] r_to_cnt,  w_to_cnt_nxt;
    logic               r_is_wr,   w_is_wr_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic [7:0]         r_addr,    w_addr_nxt;
    logic [7:0]         r_wdata,   w_wdata_nxt;
    logic               r_tx_we,   w_tx_we_nxt;
    logic               r_rx_gap;
    logic               w_rx_window;
    logic               w_rx_take;
    logic               w_rx_err;
    logic               w_to_expired;
    logic [c_cnt_w-1:0] w_to_cnt_run;

    // r_rx_gap resets high so nothing is popped in the cycle reset is released,
    // and afterwards it enforces an idle cycle after every pop.
    assign w_rx_window  = (r_state == c_idle) || (r_state == c_get_addr) || (r_state == c_get_data);
    assign w_rx_take    = w_rx_window && i_rx_valid && !r_rx_gap;
    assign w_rx_err     = i_rx_parity_err || i_rx_framing_err;
    assign w_to_expired = !i_rx_valid && (r_to_cnt == c_to_last);
    assign w_to_cnt_run = w_rx_take ? '0 : (!i_rx_valid ? r_to_cnt + c_cnt_one : r_to_cnt);

    always_comb begin
        w_state_nxt   = r_state;
        w_to_cnt_nxt  = '0;
        w_is_wr_nxt   = r_is_wr;
        w_tx_data_nxt = r_tx_data;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_tx_we_nxt   = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_rx_take) begin
                    if (!w_rx_err && (i_rx_data == c_op_write)) begin
                        w_state_nxt = c_get_addr;
                        w_is_wr_nxt = 1'b1;
                    end else if (!w_rx_err && (i_rx_data == c_op_read)) begin
                        w_state_nxt = c_get_addr;
                        w_is_wr_nxt = 1'b0;
                    end else begin
                        w_state_nxt   = c_send;
                        w_tx_data_nxt = P_NAK_BYTE;
                    end
                end
            end
            c_get_addr, c_get_data: begin
                w_to_cnt_nxt = w_to_cnt_run;
                if (w_rx_take) begin
                    if (w_rx_err) begin
                        w_state_nxt   = c_send;
                        w_tx_data_nxt = P_NAK_BYTE;
                    end else if (r_state == c_get_addr) begin
                        w_addr_nxt  = i_rx_data;
                        w_state_nxt = r_is_wr ? c_get_data : c_bus_rd;
                    end else begin
                        w_wdata_nxt = i_rx_data;
                        w_state_nxt = c_bus_wr;
                    end
                end else if (w_to_expired) begin
                    // Abandoned frame: drop silently, no response.
                    w_state_nxt  = c_idle;
                    w_to_cnt_nxt = '0;
                end
            end
            c_bus_wr: begin
                if (i_reg_ready) begin
                    w_state_nxt   = c_send;
                    w_tx_data_nxt = P_ACK_BYTE;
                end
            end
            c_bus_rd: begin
                if (i_reg_ready) begin
                    w_state_nxt   = c_send;
                    w_tx_data_nxt = i_reg_rdata;
                end
            end
            c_send: begin
                if (!i_tx_full) begin
                    w_tx_we_nxt = 1'b1;
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state   <= c_idle;
            r_to_cnt  <= '0;
            r_is_wr   <= 1'b0;
            r_tx_data <= 8'h00;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_tx_we   <= 1'b0;
            r_rx_gap  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_is_wr   <= w_is_wr_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_tx_we   <= w_tx_we_nxt;
            r_rx_gap  <= w_rx_take;
        end
    end

    assign o_rx_read_en  = w_rx_take;
    assign o_tx_data     = r_tx_data;
    assign o_tx_write_en = r_tx_we;
    assign o_reg_addr    = r_addr;
    assign o_reg_wdata   = r_wdata;
    assign o_reg_wr      = (r_state == c_bus_wr);
    assign o_reg_rd      = (r_state == c_bus_rd);
    assign o_busy        = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_bridge
// Purpose  : Scoreboard bench for uart_cmd_bridge with an RX FIFO model and
//            a register responder of programmable delay.
// Revision : 1.0
// ============================================================================
module tb_uart_cmd_bridge;

    logic       i_sys_clk = 1'b0;
    logic       i_sys_rst_n = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       i_rx_parity_err = 1'b0;
    logic       i_rx_framing_err = 1'b0;
    logic       o_rx_read_en;
    logic [7:0] o_tx_data;
    logic       o_tx_write_en;
    logic       i_tx_full = 1'b0;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_wr;
    logic       o_reg_rd;
    logic [7:0] i_reg_rdata = 8'h00;
    logic       i_reg_ready = 1'b0;
    logic       o_busy;

    uart_cmd_bridge #(
        .P_TIMEOUT_CYCLES (16),
        .P_ACK_BYTE       (8'h06),
        .P_NAK_BYTE       (8'h15)
    ) dut (
        .i_sys_clk        (i_sys_clk),
        .i_sys_rst_n      (i_sys_rst_n),
        .i_rx_data        (i_rx_data),
        .i_rx_valid       (i_rx_valid),
        .i_rx_parity_err  (i_rx_parity_err),
        .i_rx_framing_err (i_rx_framing_err),
        .o_rx_read_en     (o_rx_read_en),
        .o_tx_data        (o_tx_data),
        .o_tx_write_en    (o_tx_write_en),
        .i_tx_full        (i_tx_full),
        .o_reg_addr       (o_reg_addr),
        .o_reg_wdata      (o_reg_wdata),
        .o_reg_wr         (o_reg_wr),
        .o_reg_rd         (o_reg_rd),
        .i_reg_rdata      (i_reg_rdata),
        .i_reg_ready      (i_reg_ready),
        .o_busy           (o_busy)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    typedef struct {logic [7:0] d; logic perr; logic ferr;} rx_t;
    typedef struct {logic [7:0] d; int lat;} tx_t;
    typedef struct {logic wr; logic [7:0] addr; logic [7:0] data; int len;} reg_t;

    rx_t  rxq[$];
    tx_t  exp_tx[$];
    reg_t exp_reg[$];
    tx_t  mon_tx;
    reg_t mon_reg;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_take = 0;
    logic       pop_pend = 1'b0;
    int         run_len = 0;
    logic       run_wr = 1'b0;
    logic [7:0] run_addr = 8'h00;
    logic [7:0] run_data = 8'h00;
    logic       run_unstable = 1'b0;
    int         strb_cycles = 0;
    int         ready_delay = 0;

    always @(posedge i_sys_clk) cyc++;

    // Monitor: all DUT outputs are sampled on the falling edge.
    always @(negedge i_sys_clk) begin
        if (o_tx_write_en) begin
            n_checks++;
            if (exp_tx.size() == 0) begin
                n_errors++;
                $display("FAIL tx_unexpected: got %02h, none expected", o_tx_data);
            end else begin
                mon_tx = exp_tx.pop_front();
                if (o_tx_data !== mon_tx.d || (mon_tx.lat != 0 && (cyc - last_take) != mon_tx.lat)) begin
                    n_errors++;
                    $display("FAIL tx_byte: got %02h latency %0d, expected %02h latency %0d (0=any)",
                             o_tx_data, cyc - last_take, mon_tx.d, mon_tx.lat);
                end
            end
        end
        if (o_rx_read_en) last_take = cyc;
        pop_pend = o_rx_read_en;

        if (o_reg_wr && o_reg_rd) begin
            n_checks++;
            n_errors++;
            $display("FAIL strobe_overlap: got wr=1 rd=1, expected at most one");
        end
        if (o_reg_wr || o_reg_rd) begin
            if (run_len == 0) begin
                run_wr       = o_reg_wr;
                run_addr     = o_reg_addr;
                run_data     = o_reg_wdata;
                run_unstable = 1'b0;
            end else if (o_reg_wr !== run_wr || o_reg_addr !== run_addr || o_reg_wdata !== run_data) begin
                run_unstable = 1'b1;
            end
            run_len++;
            strb_cycles++;
        end else begin
            strb_cycles = 0;
            if (run_len != 0) begin
                n_checks++;
                if (exp_reg.size() == 0) begin
                    n_errors++;
                    $display("FAIL reg_unexpected: got wr=%0b addr=%02h len=%0d, none expected",
                             run_wr, run_addr, run_len);
                end else begin
                    mon_reg = exp_reg.pop_front();
                    if (run_wr !== mon_reg.wr || run_addr !== mon_reg.addr ||
                        (mon_reg.wr && run_data !== mon_reg.data) ||
                        (mon_reg.len != 0 && run_len != mon_reg.len) || run_unstable) begin
                        n_errors++;
                        $display("FAIL reg_access: got wr=%0b addr=%02h data=%02h len=%0d unstable=%0b, expected wr=%0b addr=%02h data=%02h len=%0d (0=any)",
                                 run_wr, run_addr, run_data, run_len, run_unstable,
                                 mon_reg.wr, mon_reg.addr, mon_reg.data, mon_reg.len);
                    end
                end
                run_len = 0;
            end
        end
    end

    task automatic drive_rx();
        if (rxq.size() > 0) begin
            i_rx_valid       = 1'b1;
            i_rx_data        = rxq[0].d;
            i_rx_parity_err  = rxq[0].perr;
            i_rx_framing_err = rxq[0].ferr;
        end else begin
            i_rx_valid       = 1'b0;
            i_rx_data        = 8'h00;
            i_rx_parity_err  = 1'b0;
            i_rx_framing_err = 1'b0;
        end
    endtask

    // One clock: apply the FIFO pop seen at the previous edge, refresh inputs.
    task automatic step();
        @(posedge i_sys_clk);
        #1;
        if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
        drive_rx();
        i_reg_ready = (o_reg_wr || o_reg_rd) && (strb_cycles >= ready_delay);
    endtask

    task automatic push_rx(input logic [7:0] d, input logic perr = 1'b0, input logic ferr = 1'b0);
        rx_t e;
        e.d = d; e.perr = perr; e.ferr = ferr;
        rxq.push_back(e);
        drive_rx();
    endtask

    task automatic exp_t(input logic [7:0] d, input int lat);
        tx_t e;
        e.d = d; e.lat = lat;
        exp_tx.push_back(e);
    endtask

    task automatic exp_r(input logic wr, input logic [7:0] addr, input logic [7:0] data, input int len);
        reg_t e;
        e.wr = wr; e.addr = addr; e.data = data; e.len = len;
        exp_reg.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int k;
        k = 0;
        while (k < max_cycles && (exp_tx.size() != 0 || exp_reg.size() != 0 || rxq.size() != 0 ||
                                  o_busy || run_len != 0)) begin
            step();
            k++;
        end
        chk({name, "_drain"}, (k < max_cycles) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset state
        step(); step();
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_reg_strobes", {30'd0, o_reg_wr, o_reg_rd}, 32'd0);
        chk("rst_pulses", {30'd0, o_rx_read_en, o_tx_write_en}, 32'd0);
        chk("rst_data", {8'd0, o_tx_data, o_reg_addr, o_reg_wdata}, 32'd0);
        i_sys_rst_n = 1'b1;
        step(); step();

        // Write frame, ready tied high
        ready_delay = 0;
        exp_r(1'b1, 8'h3C, 8'hA5, 1);
        exp_t(8'h06, 3);
        push_rx(8'h57); push_rx(8'h3C); push_rx(8'hA5);
        wait_idle("write", 60);

        // Read frame, ready after 5 cycles
        ready_delay = 5; i_reg_rdata = 8'h5A;
        exp_r(1'b0, 8'h10, 8'h00, 6);
        exp_t(8'h5A, 8);
        push_rx(8'h52); push_rx(8'h10);
        wait_idle("read", 60);

        // Bad opcode
        exp_t(8'h15, 2);
        push_rx(8'h41);
        wait_idle("bad_op", 30);
        chk("bad_op_busy", {31'd0, o_busy}, 32'd0);

        // Parity error on address byte, then a normal read
        ready_delay = 0; i_reg_rdata = 8'h77;
        exp_t(8'h15, 2);
        exp_r(1'b0, 8'h3C, 8'h00, 1);
        exp_t(8'h77, 3);
        push_rx(8'h57); push_rx(8'h3C, 1'b1, 1'b0); push_rx(8'h52); push_rx(8'h3C);
        wait_idle("perr", 80);

        // Framing error on an otherwise valid opcode
        exp_t(8'h15, 2);
        push_rx(8'h52, 1'b0, 1'b1);
        wait_idle("ferr", 30);

        // Timeout after a lone opcode
        push_rx(8'h57);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!o_busy) break;
            n++;
        end
        chk("timeout_busy_cycles", n, 16);
        i_reg_rdata = 8'h99;
        exp_r(1'b0, 8'h01, 8'h00, 1);
        exp_t(8'h99, 3);
        push_rx(8'h52); push_rx(8'h01);
        wait_idle("after_timeout", 60);

        // Transmit backpressure for 20 cycles
        i_tx_full = 1'b1; i_reg_rdata = 8'hC3;
        exp_r(1'b0, 8'h01, 8'h00, 1);
        exp_t(8'hC3, 0);
        push_rx(8'h52); push_rx(8'h01);
        for (int i = 0; i < 20; i++) step();
        chk("bp_held_busy", {31'd0, o_busy}, 32'd1);
        chk("bp_no_tx_yet", exp_tx.size(), 32'd1);
        i_tx_full = 1'b0;
        wait_idle("backpressure", 30);

        // Reset in the middle of a register read
        ready_delay = 1000; i_reg_rdata = 8'h44;
        exp_r(1'b0, 8'h01, 8'h00, 0);
        push_rx(8'h52); push_rx(8'h01);
        n = 0;
        while (!o_reg_rd && n < 20) begin step(); n++; end
        chk("rd_reached", {31'd0, o_reg_rd}, 32'd1);
        step(); step();
        i_sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_reg_rd", {31'd0, o_reg_rd}, 32'd0);
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_mid_addr", {24'd0, o_reg_addr}, 32'd0);
        push_rx(8'h41);
        #1;
        chk("rst_mid_read_en", {31'd0, o_rx_read_en}, 32'd0);
        step(); step();
        ready_delay = 0;
        exp_t(8'h15, 2);
        i_sys_rst_n = 1'b1;
        #1;
        chk("release_read_en", {31'd0, o_rx_read_en}, 32'd0);
        wait_idle("after_reset", 40);

        for (int i = 0; i < 5; i++) step();
        chk("exp_tx_left", exp_tx.size(), 32'd0);
        chk("exp_reg_left", exp_reg.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
